bp_be_acc_wide_sequencer: RTL and testbench

//  In-order sequencer between the D$ wide-data return path and the accelerator DPU.

---
 rtl/bp_be_acc_wide_sequencer_if.sv | 33 +++
 rtl/bp_be_acc_wide_sequencer.sv | 150 +++++++++++++++
 tb/tb_bp_be_acc_wide_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_acc_wide_sequencer_if.sv
// Issue, fill, flush and DPU-output signals of the wide-data sequencer.
// master drives issue/fill/flush/yumi; slave is the sequencer itself.
interface bp_be_acc_wide_sequencer_if #(
  parameter int data_width_p = 512,
  parameter int meta_width_p = 2
) ();
  logic                    issue_v_i;
  logic                    issue_hit_i;
  logic [data_width_p-1:0] issue_data_i;
  logic [meta_width_p-1:0] issue_meta_i;
  logic                    issue_ready_o;
  logic                    fill_v_i;
  logic [data_width_p-1:0] fill_data_i;
  logic                    flush_i;
  logic                    out_v_o;
  logic [data_width_p-1:0] out_data_o;
  logic [meta_width_p-1:0] out_meta_o;
  logic                    out_yumi_i;
  logic                    busy_o;
  logic                    error_o;

  modport master (
    output issue_v_i, issue_hit_i, issue_data_i, issue_meta_i,
    output fill_v_i, fill_data_i, flush_i, out_yumi_i,
    input  issue_ready_o, out_v_o, out_data_o, out_meta_o, busy_o, error_o
  );

  modport slave (
    input  issue_v_i, issue_hit_i, issue_data_i, issue_meta_i,
    input  fill_v_i, fill_data_i, flush_i, out_yumi_i,
    output issue_ready_o, out_v_o, out_data_o, out_meta_o, busy_o, error_o
  );
endinterface

// File: rtl/bp_be_acc_wide_sequencer.sv
// In-order reorder buffer between D$ wide hit/fill data and the accelerator DPU.
// Optional BP_BE_ACC_SEQ_PERF_EN adds saturating hit/miss/stall counters.
module bp_be_acc_wide_sequencer #(
  parameter int data_width_p = 512,
  parameter int meta_width_p = 2,
  parameter int els_p        = 8,
  parameter int drop_width_p = 4
) (
  input logic                       clk_i,
  input logic                       reset_n_i,
  bp_be_acc_wide_sequencer_if.slave bus
`ifdef BP_BE_ACC_SEQ_PERF_EN
  , output logic [31:0]             hit_cnt_o
  , output logic [31:0]             miss_cnt_o
  , output logic [31:0]             stall_cnt_o
`endif
);
  localparam int ptr_w_lp = $clog2(els_p);
  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [ptr_w_lp:0]   cnt_t;
  localparam cnt_t        full_cnt_lp = cnt_t'(els_p);
  localparam logic [31:0] drop_max_lp = (32'd1 << drop_width_p) - 32'd1;

  ptr_t                    head_r, tail_r;
  cnt_t                    count_r;
  logic [els_p-1:0]        done_r;
  logic [data_width_p-1:0] data_r [els_p];
  logic [meta_width_p-1:0] meta_r [els_p];

  // Miss-index FIFO: ROB slots waiting for fill data, oldest at mq_head_r.
  ptr_t                    mq_r [els_p];
  ptr_t                    mq_head_r, mq_tail_r;
  cnt_t                    mq_cnt_r;

  logic [drop_width_p-1:0] drop_r;
  logic                    error_r;

  logic        full_s, issue_ok_s, out_v_s, yumi_ok_s;
  logic        drop_nz_s, mq_nz_s, fill_drop_s, fill_wr_s, fill_err_s;
  logic        miss_push_s, drop_sat_s, err_s;
  ptr_t        fill_target_s;
  logic [31:0] drop_sum_s;

  // Handshake qualification and error detection.
  always_comb begin
    full_s        = (count_r == full_cnt_lp);
    issue_ok_s    = bus.issue_v_i & ~full_s & ~bus.flush_i;
    miss_push_s   = issue_ok_s & ~bus.issue_hit_i;
    out_v_s       = (count_r != '0) & done_r[head_r];
    yumi_ok_s     = bus.out_yumi_i & out_v_s & ~bus.flush_i;
    drop_nz_s     = (drop_r != '0);
    mq_nz_s       = (mq_cnt_r != '0);
    fill_drop_s   = bus.fill_v_i & drop_nz_s;
    fill_wr_s     = bus.fill_v_i & ~drop_nz_s & mq_nz_s;
    fill_err_s    = bus.fill_v_i & ~drop_nz_s & ~mq_nz_s;
    fill_target_s = mq_r[mq_head_r];
    // Flush folds the post-fill pending misses into the drop counter.
    drop_sum_s    = 32'(drop_r) - 32'(fill_drop_s) + 32'(mq_cnt_r) - 32'(fill_wr_s);
    drop_sat_s    = (drop_sum_s > drop_max_lp);
    err_s         = (bus.issue_v_i & full_s) | (bus.out_yumi_i & ~out_v_s)
                  | fill_err_s | (bus.flush_i & drop_sat_s);
  end

  // Pointers, occupancy, miss FIFO, drop counter and sticky error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      mq_head_r <= '0;
      mq_tail_r <= '0;
      mq_cnt_r  <= '0;
      drop_r    <= '0;
      error_r   <= 1'b0;
      for (int i = 0; i < els_p; i++) mq_r[i] <= '0;
    end else begin
      error_r <= error_r | err_s;
      if (bus.flush_i) begin
        head_r    <= '0;
        tail_r    <= '0;
        count_r   <= '0;
        mq_head_r <= '0;
        mq_tail_r <= '0;
        mq_cnt_r  <= '0;
        drop_r    <= drop_sat_s ? drop_max_lp[drop_width_p-1:0] : drop_sum_s[drop_width_p-1:0];
      end else begin
        if (issue_ok_s) tail_r <= tail_r + ptr_t'(1);
        if (yumi_ok_s)  head_r <= head_r + ptr_t'(1);
        count_r <= count_r + cnt_t'(issue_ok_s) - cnt_t'(yumi_ok_s);
        if (miss_push_s) begin
          mq_r[mq_tail_r] <= tail_r;
          mq_tail_r       <= mq_tail_r + ptr_t'(1);
        end
        if (fill_wr_s) mq_head_r <= mq_head_r + ptr_t'(1);
        mq_cnt_r <= mq_cnt_r + cnt_t'(miss_push_s) - cnt_t'(fill_wr_s);
        if (fill_drop_s) drop_r <= drop_r - {{(drop_width_p-1){1'b0}}, 1'b1};
      end
    end
  end

  // Completion bits: hits complete at issue, misses when their fill lands.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_r <= '0;
    end else begin
      if (fill_wr_s)  done_r[fill_target_s] <= 1'b1;
      if (issue_ok_s) done_r[tail_r]        <= bus.issue_hit_i;
    end
  end

  // Payload storage; never read unless the owning slot is live and done.
  always_ff @(posedge clk_i) begin
    if (fill_wr_s) data_r[fill_target_s] <= bus.fill_data_i;
    if (issue_ok_s) begin
      data_r[tail_r] <= bus.issue_data_i;
      meta_r[tail_r] <= bus.issue_meta_i;
    end
  end

  assign bus.issue_ready_o = ~full_s;
  assign bus.out_v_o       = out_v_s;
  assign bus.out_data_o    = out_v_s ? data_r[head_r] : '0;
  assign bus.out_meta_o    = out_v_s ? meta_r[head_r] : '0;
  assign bus.busy_o        = (count_r != '0) | drop_nz_s;
  assign bus.error_o       = error_r;

`ifdef BP_BE_ACC_SEQ_PERF_EN
  logic [31:0] hit_cnt_r, miss_cnt_r, stall_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_cnt_r   <= 32'd0;
      miss_cnt_r  <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (issue_ok_s & bus.issue_hit_i & (hit_cnt_r != 32'hFFFF_FFFF))
        hit_cnt_r <= hit_cnt_r + 32'd1;
      if (miss_push_s & (miss_cnt_r != 32'hFFFF_FFFF))
        miss_cnt_r <= miss_cnt_r + 32'd1;
      if (bus.issue_v_i & full_s & (stall_cnt_r != 32'hFFFF_FFFF))
        stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign hit_cnt_o   = hit_cnt_r;
  assign miss_cnt_o  = miss_cnt_r;
  assign stall_cnt_o = stall_cnt_r;
`endif
endmodule

// File: tb/tb_bp_be_acc_wide_sequencer.sv
// Directed bench for bp_be_acc_wide_sequencer: ordering, backpressure, flush/drop,
// wrap-around and asynchronous reset.
module tb_bp_be_acc_wide_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bp_be_acc_wide_sequencer_if #(.data_width_p(512), .meta_width_p(2)) bus ();

`ifdef BP_BE_ACC_SEQ_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, stall_cnt;
`endif

  bp_be_acc_wide_sequencer #(
    .data_width_p(512), .meta_width_p(2), .els_p(8), .drop_width_p(4)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
`ifdef BP_BE_ACC_SEQ_PERF_EN
    , .hit_cnt_o  (hit_cnt)
    , .miss_cnt_o (miss_cnt)
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_v_i    = 1'b0;
    bus.issue_hit_i  = 1'b0;
    bus.issue_data_i = '0;
    bus.issue_meta_i = 2'd0;
    bus.fill_v_i     = 1'b0;
    bus.fill_data_i  = '0;
    bus.flush_i      = 1'b0;
    bus.out_yumi_i   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_issue(input logic hit, input logic [511:0] d, input logic [1:0] m);
    bus.issue_v_i    = 1'b1;
    bus.issue_hit_i  = hit;
    bus.issue_data_i = d;
    bus.issue_meta_i = m;
  endtask

  function automatic logic [511:0] pat(input int n);
    pat = {16{32'hC0DE_0000 + 32'(n)}};
  endfunction

  logic [511:0] exp_q [$];
  logic [511:0] pend_q [$];

  initial begin
    idle();
    tick();
    // 1: reset values and three back-to-back hits
    chk_eq("rst_ready", 512'(bus.issue_ready_o), 512'd1);
    chk_eq("rst_out_v", 512'(bus.out_v_o), 512'd0);
    chk_eq("rst_busy",  512'(bus.busy_o), 512'd0);
    chk_eq("rst_error", 512'(bus.error_o), 512'd0);
    rst_n = 1'b1;
    tick();
    set_issue(1'b1, pat(1), 2'd1);
    tick();
    chk_eq("t1_a_v",    512'(bus.out_v_o), 512'd1);
    chk_eq("t1_a_data", bus.out_data_o, pat(1));
    chk_eq("t1_a_meta", 512'(bus.out_meta_o), 512'd1);
    set_issue(1'b1, pat(2), 2'd2);
    bus.out_yumi_i = 1'b1;
    tick();
    chk_eq("t1_b_data", bus.out_data_o, pat(2));
    set_issue(1'b1, pat(3), 2'd3);
    tick();
    chk_eq("t1_c_data", bus.out_data_o, pat(3));
    chk_eq("t1_c_meta", 512'(bus.out_meta_o), 512'd3);
    bus.issue_v_i = 1'b0;
    tick();
    bus.out_yumi_i = 1'b0;
    chk_eq("t1_empty_v", 512'(bus.out_v_o), 512'd0);
    chk_eq("t1_busy",    512'(bus.busy_o), 512'd0);
    chk_eq("t1_error",   512'(bus.error_o), 512'd0);

    // 2: miss ahead of two hits holds output until fill
    set_issue(1'b0, {512{1'b1}}, 2'd2);
    tick();
    chk_eq("t2_m_v", 512'(bus.out_v_o), 512'd0);
    set_issue(1'b1, pat(21), 2'd0);
    tick();
    set_issue(1'b1, pat(22), 2'd1);
    tick();
    bus.issue_v_i = 1'b0;
    chk_eq("t2_wait_v", 512'(bus.out_v_o), 512'd0);
    tick();
    chk_eq("t2_wait_busy", 512'(bus.busy_o), 512'd1);
    bus.fill_v_i = 1'b1;
    bus.fill_data_i = pat(20);
    tick();
    bus.fill_v_i = 1'b0;
    chk_eq("t2_m_data", bus.out_data_o, pat(20));
    chk_eq("t2_m_meta", 512'(bus.out_meta_o), 512'd2);
    bus.out_yumi_i = 1'b1;
    tick();
    chk_eq("t2_h1_data", bus.out_data_o, pat(21));
    tick();
    chk_eq("t2_h2_data", bus.out_data_o, pat(22));
    tick();
    bus.out_yumi_i = 1'b0;
    chk_eq("t2_empty_v", 512'(bus.out_v_o), 512'd0);
    chk_eq("t2_error",   512'(bus.error_o), 512'd0);

    // 3: fill to 8, reject 9th, full issue+yumi, drain
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk_eq("t3_ready_at7", 512'(bus.issue_ready_o), 512'd1);
      set_issue(1'b1, pat(100 + i), 2'(i));
      tick();
    end
    chk_eq("t3_ready_full", 512'(bus.issue_ready_o), 512'd0);
    chk_eq("t3_err_before", 512'(bus.error_o), 512'd0);
    set_issue(1'b1, pat(999), 2'd0);
    tick();
    chk_eq("t3_err_9th",  512'(bus.error_o), 512'd1);
    chk_eq("t3_head_9th", bus.out_data_o, pat(100));
    bus.out_yumi_i = 1'b1;
    tick();
    bus.issue_v_i = 1'b0;
    chk_eq("t3_yumi_full_ready", 512'(bus.issue_ready_o), 512'd1);
    for (int k = 1; k < 8; k++) begin
      chk_eq($sformatf("t3_drain%0d", k), bus.out_data_o, pat(100 + k));
      tick();
    end
    bus.out_yumi_i = 1'b0;
    chk_eq("t3_empty_busy", 512'(bus.busy_o), 512'd0);

    // 4: flush with two misses outstanding, then three fills
    do_reset();
    chk_eq("t4_err_cleared", 512'(bus.error_o), 512'd0);
    set_issue(1'b0, '0, 2'd0);
    tick();
    tick();
    bus.issue_v_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk_eq("t4_flush_v",    512'(bus.out_v_o), 512'd0);
    chk_eq("t4_flush_busy", 512'(bus.busy_o), 512'd1);
    bus.fill_v_i = 1'b1;
    bus.fill_data_i = pat(41);
    tick();
    chk_eq("t4_f1_busy", 512'(bus.busy_o), 512'd1);
    bus.fill_data_i = pat(42);
    tick();
    chk_eq("t4_f2_busy",  512'(bus.busy_o), 512'd0);
    chk_eq("t4_f2_error", 512'(bus.error_o), 512'd0);
    bus.fill_data_i = pat(43);
    tick();
    bus.fill_v_i = 1'b0;
    chk_eq("t4_f3_error", 512'(bus.error_o), 512'd1);
    chk_eq("t4_f3_v",     512'(bus.out_v_o), 512'd0);

    // 4b: drop counter saturation (8 + 8 pending > 15)
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_issue(1'b0, '0, 2'd0);
      for (int i = 0; i < 8; i++) tick();
      bus.issue_v_i = 1'b0;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      if (r == 0) chk_eq("t4b_no_sat", 512'(bus.error_o), 512'd0);
    end
    chk_eq("t4b_sat_error", 512'(bus.error_o), 512'd1);
    chk_eq("t4b_sat_busy",  512'(bus.busy_o), 512'd1);

    // 5: 20 mixed ops with random fill/yumi timing across ROB wrap
    do_reset();
    begin
      int n = 0;
      int cyc = 0;
      int got = 0;
      while ((n < 20 || exp_q.size() != 0) && cyc < 600) begin
        idle();
        if (pend_q.size() != 0 && ($urandom % 2) == 1) begin
          bus.fill_v_i = 1'b1;
          bus.fill_data_i = pend_q.pop_front();
        end
        if (n < 20 && bus.issue_ready_o) begin
          if ((n % 3) == 1) begin
            set_issue(1'b0, {512{1'b1}}, 2'd0);
            pend_q.push_back(pat(500 + n));
          end else begin
            set_issue(1'b1, pat(500 + n), 2'd1);
          end
          exp_q.push_back(pat(500 + n));
          n++;
        end
        if (bus.out_v_o && ($urandom % 3) != 0) begin
          chk_eq($sformatf("t5_order%0d", got), bus.out_data_o, exp_q.pop_front());
          bus.out_yumi_i = 1'b1;
          got++;
        end
        tick();
        cyc++;
      end
      idle();
      chk_eq("t5_delivered", 512'(got), 512'd20);
      chk_eq("t5_busy",  512'(bus.busy_o), 512'd0);
      chk_eq("t5_error", 512'(bus.error_o), 512'd0);
    end

    // 6: asynchronous reset with five entries live
    for (int i = 0; i < 5; i++) begin
      set_issue(1'b1, pat(600 + i), 2'd3);
      tick();
    end
    bus.issue_v_i = 1'b0;
    chk_eq("t6_pre_v", 512'(bus.out_v_o), 512'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6_async_v",     512'(bus.out_v_o), 512'd0);
    chk_eq("t6_async_data",  bus.out_data_o, 512'd0);
    chk_eq("t6_async_meta",  512'(bus.out_meta_o), 512'd0);
    chk_eq("t6_async_busy",  512'(bus.busy_o), 512'd0);
    chk_eq("t6_async_ready", 512'(bus.issue_ready_o), 512'd1);
    tick();
    rst_n = 1'b1;
    tick();
    set_issue(1'b1, pat(700), 2'd2);
    tick();
    bus.issue_v_i = 1'b0;
    chk_eq("t6_restart_data", bus.out_data_o, pat(700));
    bus.out_yumi_i = 1'b1;
    tick();
    bus.out_yumi_i = 1'b0;
    chk_eq("t6_restart_busy",  512'(bus.busy_o), 512'd0);
    chk_eq("t6_restart_error", 512'(bus.error_o), 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
